// File: rtl/axi_master.sv
// Bridges the core's single-outstanding load/store port onto an AXI4-Lite master.
// One transaction in flight; completion is reported by a one-cycle cpu_done pulse.
module axi_master #(
  parameter logic [2:0] PROT        = 3'b000,
  parameter bit         ALIGN_CHECK = 1'b1
) (
  input  logic        ACLK,
  input  logic        ARESETN,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_wstrb,
  output logic        cpu_ready,
  output logic        cpu_done,
  output logic [31:0] cpu_rdata,
  output logic        cpu_err,
  output logic [31:0] ARADDR,
  output logic [2:0]  ARPROT,
  output logic        ARVALID,
  input  logic        ARREADY,
  input  logic [31:0] RDATA,
  input  logic [1:0]  RRESP,
  input  logic        RVALID,
  output logic        RREADY,
  output logic [31:0] AWADDR,
  output logic [2:0]  AWPROT,
  output logic        AWVALID,
  input  logic        AWREADY,
  output logic [31:0] WDATA,
  output logic [3:0]  WSTRB,
  output logic        WVALID,
  input  logic        WREADY,
  input  logic [1:0]  BRESP,
  input  logic        BVALID,
  output logic        BREADY
);

  typedef enum logic [2:0] {StIdle, StRdAddr, StRdData, StWrReq, StWrResp} state_e;

  state_e      state_q, state_d;
  logic [31:0] araddr_q, araddr_d, awaddr_q, awaddr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        arvalid_q, arvalid_d, rready_q, rready_d;
  logic        awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic        done_q, done_d, err_q, err_d;
  logic        aw_ok_q, aw_ok_d, w_ok_q, w_ok_d;
  logic        misaligned, aw_done, w_done;

  assign misaligned = ALIGN_CHECK && (cpu_addr[1:0] != 2'b00);
  // A channel counts as complete on the very edge its handshake happens.
  assign aw_done    = aw_ok_q | (awvalid_q & AWREADY);
  assign w_done     = w_ok_q | (wvalid_q & WREADY);

  always_comb begin
    state_d   = state_q;
    araddr_d  = araddr_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    done_d    = 1'b0;
    err_d     = err_q;
    aw_ok_d   = aw_ok_q;
    w_ok_d    = w_ok_q;
    unique case (state_q)
      StIdle: begin
        if (cpu_req) begin
          if (misaligned) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end else if (cpu_we) begin
            state_d   = StWrReq;
            awaddr_d  = cpu_addr;
            wdata_d   = cpu_wdata;
            wstrb_d   = cpu_wstrb;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_ok_d   = 1'b0;
            w_ok_d    = 1'b0;
          end else begin
            state_d   = StRdAddr;
            araddr_d  = cpu_addr;
            arvalid_d = 1'b1;
          end
        end
      end
      StRdAddr: begin
        if (ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = StRdData;
        end
      end
      StRdData: begin
        if (RVALID) begin
          rdata_d  = RDATA;
          err_d    = (RRESP != 2'b00);
          done_d   = 1'b1;
          rready_d = 1'b0;
          state_d  = StIdle;
        end
      end
      StWrReq: begin
        if (awvalid_q && AWREADY) begin
          awvalid_d = 1'b0;
          aw_ok_d   = 1'b1;
        end
        if (wvalid_q && WREADY) begin
          wvalid_d = 1'b0;
          w_ok_d   = 1'b1;
        end
        if (aw_done && w_done) begin
          state_d  = StWrResp;
          bready_d = 1'b1;
          aw_ok_d  = 1'b0;
          w_ok_d   = 1'b0;
        end
      end
      StWrResp: begin
        if (BVALID) begin
          err_d    = (BRESP != 2'b00);
          done_d   = 1'b1;
          bready_d = 1'b0;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_q   <= StIdle;
      araddr_q  <= '0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      aw_ok_q   <= 1'b0;
      w_ok_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      araddr_q  <= araddr_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rdata_q   <= rdata_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      done_q    <= done_d;
      err_q     <= err_d;
      aw_ok_q   <= aw_ok_d;
      w_ok_q    <= w_ok_d;
    end
  end

  assign cpu_ready = (state_q == StIdle);
  assign cpu_done  = done_q;
  assign cpu_rdata = rdata_q;
  assign cpu_err   = err_q;
  assign ARADDR    = araddr_q;
  assign ARPROT    = PROT;
  assign ARVALID   = arvalid_q;
  assign RREADY    = rready_q;
  assign AWADDR    = awaddr_q;
  assign AWPROT    = PROT;
  assign AWVALID   = awvalid_q;
  assign WDATA     = wdata_q;
  assign WSTRB     = wstrb_q;
  assign WVALID    = wvalid_q;
  assign BREADY    = bready_q;

endmodule
